// File: rtl/audio_sample_bridge.sv
// Codec sample bridge: RX samples are attenuated or muted per channel, tagged with
// their channel, buffered in a FIFO and handed to the TX codec in channel order.
module audio_sample_bridge #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 8,
  parameter int SHIFT_W      = 3
) (
  input  logic                             lmmi_clk_i,
  input  logic                             reset_n_i,
  input  logic                             enable_i,
  input  logic [31:0]                      adc_data_i,
  input  logic                             adc_valid_i,
  input  logic                             dac_request_i,
  input  logic [NUM_CHANNELS*SHIFT_W-1:0]  attn_i,
  input  logic [NUM_CHANNELS-1:0]          mute_i,
  input  logic                             clear_flags_i,
  output logic [31:0]                      dac_data_o,
  output logic [$clog2(FIFO_DEPTH):0]      fill_o,
  output logic                             overrun_o,
  output logic                             underrun_o,
  output logic                             sync_err_o
);
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  logic [CH_W-1:0]       rx_ch, tx_ch;
  logic                  s1_valid;
  logic [CH_W-1:0]       s1_tag;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]       mem_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [SHIFT_W-1:0]    shamt;
  logic                  ch_mute;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  rx_take, tx_take, fifo_empty, fifo_full;
  logic                  pop, wr_ok, wr_drop, hit;

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^adc_data_i[31:DATA_WIDTH];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shamt   = '0;
    ch_mute = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rx_ch == CH_W'(c)) begin
        shamt   = attn_i[c*SHIFT_W +: SHIFT_W];
        ch_mute = mute_i[c];
      end
    end
  end

  assign shifted    = $signed(adc_data_i[DATA_WIDTH-1:0]) >>> shamt;
  assign rx_take    = enable_i & adc_valid_i;
  assign tx_take    = enable_i & dac_request_i;
  assign fifo_empty = (fill_o == '0);
  assign fifo_full  = (fill_o == FILL_W'(FIFO_DEPTH));
  assign pop        = tx_take & ~fifo_empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign wr_ok      = enable_i & s1_valid & (~fifo_full | pop);
  assign wr_drop    = enable_i & s1_valid & fifo_full & ~pop;
  assign hit        = (mem_tag[rd_ptr] == tx_ch);

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_ch    <= '0;
      tx_ch    <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_data  <= '0;
    end else if (!enable_i) begin
      rx_ch    <= '0;
      tx_ch    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rx_take;
      if (rx_take) begin
        rx_ch   <= (rx_ch == LAST_CH) ? '0 : rx_ch + 1'b1;
        s1_tag  <= rx_ch;
        s1_data <= ch_mute ? '0 : shifted;
      end
      if (tx_take) tx_ch <= (tx_ch == LAST_CH) ? '0 : tx_ch + 1'b1;
    end
  end

  // NOTE: sample storage has no reset; pointers and fill alone decide what is valid.
  always_ff @(posedge lmmi_clk_i) begin
    if (wr_ok) begin
      mem_data[wr_ptr] <= s1_data;
      mem_tag[wr_ptr]  <= s1_tag;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      dac_data_o <= '0;
    end else if (!enable_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      dac_data_o <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fill_o <= fill_o + 1'b1;
        2'b01:   fill_o <= fill_o - 1'b1;
        default: fill_o <= fill_o;
      endcase
      // Misses (empty or wrong channel) output silence; the head is dropped on a wrong channel.
      if (tx_take) dac_data_o <= (pop && hit) ? 32'(mem_data[rd_ptr]) : '0;
    end
  end

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
      sync_err_o <= 1'b0;
    end else begin
      if (clear_flags_i) begin
        overrun_o  <= 1'b0;
        underrun_o <= 1'b0;
        sync_err_o <= 1'b0;
      end
      if (wr_drop)                overrun_o  <= 1'b1;
      if (tx_take && fifo_empty)  underrun_o <= 1'b1;
      if (pop && !hit)            sync_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_bridge.sv
// Self-checking bench for audio_sample_bridge: directed scenarios plus randomized
// push/request traffic against a queue-based model of the bridge.
module tb_audio_sample_bridge;
  localparam int DW = 24, NCH = 2, DEPTH = 8, SW = 3;

  logic          clk = 1'b0;
  logic          rst_n, enable, adc_valid, dac_req, clear_flags;
  logic [31:0]   adc_data;
  logic [NCH*SW-1:0] attn;
  logic [NCH-1:0]    mute;
  logic [31:0]   dac_data;
  logic [3:0]    fill;
  logic          overrun, underrun, sync_err;

  audio_sample_bridge #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .SHIFT_W(SW)) dut (
    .lmmi_clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .adc_data_i(adc_data),
    .adc_valid_i(adc_valid), .dac_request_i(dac_req), .attn_i(attn), .mute_i(mute),
    .clear_flags_i(clear_flags), .dac_data_o(dac_data), .fill_o(fill),
    .overrun_o(overrun), .underrun_o(underrun), .sync_err_o(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; logic [31:0] val; } entry_t;
  entry_t      q[$];
  int          m_rx, m_tx;
  bit          m_ovr, m_und, m_syn;
  logic [31:0] m_dac;
  int          passed = 0, total = 0;

  // Value a sample should have in the buffer: sign-extend, shift, mask to width.
  function automatic logic [31:0] model_val(input logic [31:0] raw, input int sh, input bit m);
    logic signed [31:0] v;
    if (m) return 32'h0;
    v = $signed(raw << (32 - DW));
    v = v >>> (32 - DW);
    v = v >>> sh;
    return v & ((32'h1 << DW) - 1);
  endfunction

  task automatic model_push(input logic [31:0] raw);
    entry_t e;
    e.tag = m_rx;
    e.val = model_val(raw, int'(attn[m_rx*SW +: SW]), mute[m_rx]);
    m_rx = (m_rx + 1) % NCH;
    if (q.size() < DEPTH) q.push_back(e);
    else m_ovr = 1'b1;
  endtask

  task automatic model_request();
    entry_t e;
    int ch;
    ch = m_tx;
    m_tx = (m_tx + 1) % NCH;
    if (q.size() == 0) begin
      m_dac = 32'h0; m_und = 1'b1;
    end else begin
      e = q.pop_front();
      if (e.tag == ch) m_dac = e.val;
      else begin m_dac = 32'h0; m_syn = 1'b1; end
    end
  endtask

  task automatic model_clear();
    q.delete(); m_rx = 0; m_tx = 0; m_dac = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; adc_valid = 1'b0; dac_req = 1'b0; clear_flags = 1'b0;
    adc_data = '0; attn = '0; mute = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear(); m_ovr = 0; m_und = 0; m_syn = 0;
  endtask

  // Called right after a falling edge; returns after the sample has landed in the FIFO.
  task automatic do_push(input logic [31:0] d);
    adc_data = d; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    model_push(d);
  endtask

  task automatic do_request();
    dac_req = 1'b1;
    @(negedge clk);
    dac_req = 1'b0;
    model_request();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; adc_valid = 1'b0; dac_req = 1'b0; clear_flags = 1'b0;
    adc_data = '0; attn = '0; mute = '0;
    #1;
    total++; if (dac_data !== 32'h0) $display("FAIL reset_dac: got %h want 0", dac_data); else passed++;
    total++; if (fill !== 4'd0) $display("FAIL reset_fill: got %0d want 0", fill); else passed++;
    total++; if ({overrun, underrun, sync_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {overrun, underrun, sync_err}); else passed++;
    do_reset();
  endtask

  task automatic test_passthrough();
    do_reset();
    do_push(32'h123456);
    total++; if (fill !== 4'd1) $display("FAIL pt_fill1: got %0d want 1", fill); else passed++;
    do_push(32'hFEDCBA);
    total++; if (fill !== 4'd2) $display("FAIL pt_fill2: got %0d want 2", fill); else passed++;
    do_request();
    total++; if (dac_data !== 32'h00123456) $display("FAIL pt_left: got %h want 00123456", dac_data); else passed++;
    total++; if (fill !== 4'd1) $display("FAIL pt_fill3: got %0d want 1", fill); else passed++;
    do_request();
    total++; if (dac_data !== 32'h00FEDCBA) $display("FAIL pt_right: got %h want 00FEDCBA", dac_data); else passed++;
    total++; if (fill !== 4'd0) $display("FAIL pt_fill4: got %0d want 0", fill); else passed++;
    repeat (3) @(negedge clk);
    total++; if (dac_data !== 32'h00FEDCBA) $display("FAIL pt_hold: got %h want 00FEDCBA", dac_data); else passed++;
  endtask

  task automatic test_attn();
    do_reset();
    attn = {3'd0, 3'd3}; mute = 2'b10;
    do_push(32'h800000);
    do_push(32'h7FFFFF);
    do_push(32'h000100);
    attn = '0;   // changed after capture: must not affect the stored sample
    do_request();
    total++; if (dac_data !== 32'h00F00000) $display("FAIL attn_ch0: got %h want 00F00000", dac_data); else passed++;
    do_request();
    total++; if (dac_data !== 32'h00000000) $display("FAIL mute_ch1: got %h want 00000000", dac_data); else passed++;
    do_request();
    total++; if (dac_data !== 32'h00000020) $display("FAIL attn_sampled: got %h want 00000020", dac_data); else passed++;
    total++; if (sync_err !== 1'b0) $display("FAIL attn_sync: got %b want 0", sync_err); else passed++;
    mute = '0;
  endtask

  task automatic test_overrun();
    logic [31:0] d [9];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      d[i] = {8'h0, 24'(i + 1) * 24'h010203};
      do_push(d[i]);
    end
    total++; if (fill !== 4'd8) $display("FAIL ovr_fill: got %0d want 8", fill); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    for (int i = 0; i < 8; i++) begin
      do_request();
      total++; if (dac_data !== d[i]) $display("FAIL ovr_drain%0d: got %h want %h", i, dac_data, d[i]); else passed++;
    end
    do_request();
    total++; if (dac_data !== 32'h0 || underrun !== 1'b1) $display("FAIL ovr_ninth: got %h/%b want 0/1", dac_data, underrun); else passed++;
  endtask

  task automatic test_underrun_slip();
    do_reset();
    do_request();
    total++; if (dac_data !== 32'h0 || underrun !== 1'b1) $display("FAIL und_empty: got %h/%b want 0/1", dac_data, underrun); else passed++;
    do_push(32'h0A0A0A);
    do_push(32'h0B0B0B);
    do_request();
    total++; if (dac_data !== 32'h0 || sync_err !== 1'b1) $display("FAIL slip_drop: got %h/%b want 0/1", dac_data, sync_err); else passed++;
    total++; if (fill !== 4'd1) $display("FAIL slip_fill: got %0d want 1", fill); else passed++;
    do_request();
    total++; if (dac_data !== m_dac) $display("FAIL slip_second: got %h want %h", dac_data, m_dac); else passed++;
    total++; if (fill !== 4'(q.size())) $display("FAIL slip_fill2: got %0d want %0d", fill, q.size()); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 8; i++) do_push(32'h000011 * (i + 1));
    adc_data = 32'h0055AA; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; dac_req = 1'b1;
    @(negedge clk);
    dac_req = 1'b0;
    model_request(); model_push(32'h0055AA);
    total++; if (fill !== 4'd8) $display("FAIL full_rw_fill: got %0d want 8", fill); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL full_rw_ovr: got %b want 0", overrun); else passed++;
    total++; if (dac_data !== m_dac) $display("FAIL full_rw_data: got %h want %h", dac_data, m_dac); else passed++;
    do_reset();
    adc_data = 32'h00ABCD; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; dac_req = 1'b1;
    @(negedge clk);
    dac_req = 1'b0;
    model_request(); model_push(32'h00ABCD);
    total++; if (dac_data !== 32'h0) $display("FAIL no_bypass_data: got %h want 0", dac_data); else passed++;
    total++; if (underrun !== 1'b1 || fill !== 4'd1) $display("FAIL no_bypass_state: got %b/%0d want 1/1", underrun, fill); else passed++;
  endtask

  task automatic test_clear_flags();
    do_reset();
    do_request();
    for (int i = 0; i < 9; i++) do_push(32'h000100 + i);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    m_ovr = 0; m_und = 0; m_syn = 0;
    total++; if ({overrun, underrun, sync_err} !== 3'b000) $display("FAIL clr_all: got %b want 000", {overrun, underrun, sync_err}); else passed++;
    clear_flags = 1'b1;
    do_request();
    clear_flags = 1'b0;
    total++; if ({overrun, underrun, sync_err} !== {m_ovr, m_und, m_syn}) $display("FAIL clr_set_wins: got %b want %b", {overrun, underrun, sync_err}, {m_ovr, m_und, m_syn}); else passed++;
  endtask

  task automatic test_enable();
    do_reset();
    do_request();
    for (int i = 0; i < 3; i++) do_push(32'h000200 + i);
    total++; if (fill !== 4'd3) $display("FAIL en_pre_fill: got %0d want 3", fill); else passed++;
    enable = 1'b0;
    @(negedge clk);
    total++; if (fill !== 4'd0 || dac_data !== 32'h0) $display("FAIL en_flush: got %0d/%h want 0/0", fill, dac_data); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL en_flags_kept: got %b want 1", underrun); else passed++;
    adc_data = 32'h00FFFF; adc_valid = 1'b1; dac_req = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0; dac_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (fill !== 4'd0 || {overrun, sync_err} !== 2'b00) $display("FAIL en_ignore: got %0d/%b want 0/00", fill, {overrun, sync_err}); else passed++;
    enable = 1'b1;
    model_clear();
    do_push(32'h0ABCDE);
    do_request();
    total++; if (dac_data !== 32'h000ABCDE) $display("FAIL en_realign: got %h want 000ABCDE", dac_data); else passed++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    do_request(); do_request();
    for (int i = 0; i < 6; i++) do_push(32'h111111 * (i + 1));
    do_request();
    total++; if (fill !== 4'd5 || dac_data !== 32'h00111111) $display("FAIL rst_pre: got %0d/%h want 5/00111111", fill, dac_data); else passed++;
    adc_data = 32'h00CAFE; adc_valid = 1'b1;
    @(posedge clk);
    #1 adc_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++; if (dac_data !== 32'h0 || fill !== 4'd0) $display("FAIL rst_async_out: got %h/%0d want 0/0", dac_data, fill); else passed++;
    total++; if ({overrun, underrun, sync_err} !== 3'b000) $display("FAIL rst_async_flags: got %b want 000", {overrun, underrun, sync_err}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear(); m_ovr = 0; m_und = 0; m_syn = 0;
    repeat (2) @(negedge clk);
    total++; if (fill !== 4'd0) $display("FAIL rst_inflight: got %0d want 0", fill); else passed++;
    do_push(32'h0BEEF0);
    do_request();
    total++; if (dac_data !== 32'h000BEEF0) $display("FAIL rst_ch0: got %h want 000BEEF0", dac_data); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      attn = NCH*SW'($urandom);
      mute = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
      if ($urandom_range(0, 99) < 55) begin
        d = $urandom;
        do_push(d);
      end else begin
        do_request();
        total++; if (dac_data !== m_dac) $display("FAIL rnd_data[%0d]: got %h want %h", n, dac_data, m_dac); else passed++;
      end
      total++; if (fill !== 4'(q.size())) $display("FAIL rnd_fill[%0d]: got %0d want %0d", n, fill, q.size()); else passed++;
      total++; if ({overrun, underrun, sync_err} !== {m_ovr, m_und, m_syn}) $display("FAIL rnd_flags[%0d]: got %b want %b", n, {overrun, underrun, sync_err}, {m_ovr, m_und, m_syn}); else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_attn();
    test_overrun();
    test_underrun_slip();
    test_same_cycle();
    test_clear_flags();
    test_enable();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
